rf_wb_arbiter: RTL

Write-port arbiter and hazard scoreboard for the 32 x 64-bit register file. It shares the file's single write port between the single-cycle ALU writeback path (A) and the multi-cycle load/long-latency unit (B), and registers the winning write one cycle before the file commits it. It also tracks destination registers that have an outstanding B write and raises a hazard to decode until each write lands. X31 (XZR) is never written and never marked pending.

---
 rtl/rf_wb_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter for the 32 x 64-bit register file, sharing one registered
// write port between the ALU (A) and load/long-latency (B) paths, plus a B-write hazard scoreboard.
module rf_wb_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [4:0]  issue_Rd,
    input  logic [4:0]  Rn,
    input  logic [4:0]  Rm,
    input  logic [4:0]  dec_Rd,
    output logic        hazard,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_Rd,
    input  logic [63:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_Rd,
    input  logic [63:0] b_data,
    output logic [4:0]  Rd,
    output logic [63:0] data_write,
    output logic        reg_wr,
    output logic [5:0]  pending_cnt
);

    // Handshake: a transfer happens when valid && ready at a rising edge; a
    // requester holds Rd/data stable while valid && !ready. At most one of
    // A and B transfers per cycle; A wins unless B has hit its starvation limit.
    logic [3:0]  starve_cnt;
    logic        starve_hit;
    logic        a_xfer;
    logic        b_xfer;
    logic [31:0] sb;
    logic [31:0] sb_next;
    logic [5:0]  sb_pop;
    logic        commit_b;

    always_comb begin
        starve_hit = (starve_cnt == 4'(STARVE_MAX));
        a_ready    = !(b_valid && starve_hit);
        b_ready    = b_valid && (!a_valid || starve_hit);
        a_xfer     = a_valid && a_ready;
        b_xfer     = b_valid && b_ready;
        hazard     = sb[Rn] | sb[Rm] | sb[dec_Rd];
    end

    // Clear applies first so a same-edge set on the same bit wins.
    always_comb begin
        sb_next = sb;
        if (reg_wr && commit_b)
            sb_next[Rd] = 1'b0;
        if (issue_valid && !hazard && issue_Rd != 5'd31)
            sb_next[issue_Rd] = 1'b1;
        sb_next[31] = 1'b0;
    end

    always_comb begin
        sb_pop = 6'd0;
        for (int i = 0; i < 32; i++)
            sb_pop = sb_pop + 6'(sb_next[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt  <= 4'd0;
            sb          <= 32'd0;
            pending_cnt <= 6'd0;
            Rd          <= 5'd0;
            data_write  <= 64'd0;
            reg_wr      <= 1'b0;
            commit_b    <= 1'b0;
        end else begin
            sb          <= sb_next;
            pending_cnt <= sb_pop;

            if (!b_valid || b_xfer)
                starve_cnt <= 4'd0;
            else if (!starve_hit)
                starve_cnt <= starve_cnt + 4'd1;

            if (a_xfer) begin
                Rd         <= a_Rd;
                data_write <= a_data;
                reg_wr     <= (a_Rd != 5'd31);
                commit_b   <= 1'b0;
            end else if (b_xfer) begin
                Rd         <= b_Rd;
                data_write <= b_data;
                reg_wr     <= (b_Rd != 5'd31);
                commit_b   <= (b_Rd != 5'd31);
            end else begin
                reg_wr   <= 1'b0;
                commit_b <= 1'b0;
            end
        end
    end

endmodule
